// File: rtl/data_sram_bridge_if.sv
// Request/response bus between the data-SRAM bridge (master) and the memory
// system (slave): single-outstanding valid/ready request, one-cycle response pulse.
interface data_sram_bridge_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) ();
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_wr;
    logic [DATA_W/8-1:0]   req_wstrb;
    logic [ADDR_W-1:0]     req_addr;
    logic [DATA_W-1:0]     req_wdata;
    logic                  resp_valid;
    logic [DATA_W-1:0]     resp_rdata;

    modport master (
        output req_valid, req_wr, req_wstrb, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata
    );

    modport slave (
        input  req_valid, req_wr, req_wstrb, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata
    );
endinterface

// File: rtl/data_sram_bridge.sv
// Turns the core's one-cycle data-SRAM port into a single-outstanding valid/ready
// bus transaction, stalling the pipeline while the access is in flight.
module data_sram_bridge #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                data_sram_en,
    input  logic [DATA_W/8-1:0] data_sram_wen,
    input  logic [ADDR_W-1:0]   data_sram_addr,
    input  logic [DATA_W-1:0]   data_sram_wdata,
    output logic [DATA_W-1:0]   data_sram_rdata,
    output logic                stallreq,
    output logic                bus_err,
    data_sram_bridge_if.master  bus
);
    localparam int                CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [DATA_W-1:0] ERR_DATA = DATA_W'(32'hDEAD_BEEF);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_wr;
    logic [DATA_W/8-1:0] r_wstrb;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W-1:0]   r_rdata;
    logic                r_err;
    logic                w_timeout;

    assign w_timeout = (r_cnt == CNT_LAST);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (data_sram_en) w_state_next = S_REQ;
            S_REQ:   if (bus.req_ready) w_state_next = S_WAIT;
            S_WAIT:  if (bus.resp_valid || w_timeout) w_state_next = S_DONE;
            // The stalled instruction still drives en here; it must not re-issue.
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_wr    <= 1'b0;
            r_wstrb <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                S_IDLE: begin
                    if (data_sram_en) begin
                        r_wr    <= |data_sram_wen;
                        r_wstrb <= data_sram_wen;
                        r_addr  <= data_sram_addr;
                        r_wdata <= data_sram_wdata;
                    end
                end
                S_REQ: begin
                    if (bus.req_ready) r_cnt <= '0;
                end
                S_WAIT: begin
                    // A response in the final wait cycle beats the timeout.
                    if (bus.resp_valid) begin
                        if (!r_wr) r_rdata <= bus.resp_rdata;
                    end else if (w_timeout) begin
                        if (!r_wr) r_rdata <= ERR_DATA;
                        r_err <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign stallreq        = ((r_state == S_IDLE) && data_sram_en)
                           || (r_state == S_REQ) || (r_state == S_WAIT);
    assign data_sram_rdata = r_rdata;
    assign bus_err         = r_err;

    assign bus.req_valid = (r_state == S_REQ);
    assign bus.req_wr    = r_wr;
    assign bus.req_wstrb = r_wstrb;
    assign bus.req_addr  = r_addr;
    assign bus.req_wdata = r_wdata;
endmodule

// File: tb/tb_data_sram_bridge.sv
// Self-checking bench: transactions are scheduled from (ready delay, response delay)
// and every cycle's expected outputs are derived from that schedule.
module tb_data_sram_bridge;
    localparam int TIMEOUT = 255;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en;
    logic [3:0]  wen;
    logic [31:0] addr, wdata;
    logic [31:0] data_sram_rdata;
    logic        stallreq, bus_err;

    always #5 clk = ~clk;

    data_sram_bridge_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    data_sram_bridge #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TIMEOUT)) dut (
        .clk             (clk),
        .rst             (rst),
        .data_sram_en    (en),
        .data_sram_wen   (wen),
        .data_sram_addr  (addr),
        .data_sram_wdata (wdata),
        .data_sram_rdata (data_sram_rdata),
        .stallreq        (stallreq),
        .bus_err         (bus_err),
        .bus             (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int hs_cnt = 0;
    int stall_cnt = 0;

    // Model state and per-cycle expectations
    logic [31:0] m_rdata;
    bit          m_err;
    bit          chk_on;
    bit          e_stall, e_valid, e_wr, e_err;
    logic [3:0]  e_strb;
    logic [31:0] e_addr, e_wdata, e_rd;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            check("stallreq", 32'(stallreq), 32'(e_stall));
            check("req_valid", 32'(bus.req_valid), 32'(e_valid));
            check("rdata", data_sram_rdata, e_rd);
            check("bus_err", 32'(bus_err), 32'(e_err));
            if (e_valid) begin
                check("req_wr", 32'(bus.req_wr), 32'(e_wr));
                check("req_wstrb", 32'(bus.req_wstrb), 32'(e_strb));
                check("req_addr", bus.req_addr, e_addr);
                check("req_wdata", bus.req_wdata, e_wdata);
            end
        end
        if (!rst && bus.req_valid && bus.req_ready) hs_cnt++;
        if (stallreq) stall_cnt++;
    end

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            en = 1'b0; wen = 4'($urandom); addr = $urandom; wdata = $urandom;
            bus.req_ready  = 1'($urandom_range(0, 1));
            bus.resp_valid = 1'($urandom_range(0, 1));
            bus.resp_rdata = $urandom;
            e_stall = 1'b0; e_valid = 1'b0; e_rd = m_rdata; e_err = m_err;
            @(posedge clk); #1;
        end
    endtask

    // d = REQ cycles with ready low; r = WAIT cycle index of the response
    // (r >= TIMEOUT means the response never comes).
    task automatic txn(input logic [3:0] w, input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] rd, input int d, input int r, input bit hold);
        bit          to     = (r >= TIMEOUT);
        int          wl     = to ? TIMEOUT - 1 : r;
        int          last   = 3 + d + wl;
        int          hs0    = hs_cnt;
        logic [31:0] new_rd = (w != 4'd0) ? m_rdata : (to ? 32'hDEAD_BEEF : rd);
        for (int k = 0; k <= last; k++) begin
            if (k == 0 || hold) begin
                en = 1'b1; wen = w; addr = a; wdata = wd;
            end else begin
                en = 1'($urandom_range(0, 1)); wen = 4'($urandom); addr = $urandom; wdata = $urandom;
            end
            if (k >= 1 && k <= d)  bus.req_ready = 1'b0;
            else if (k == 1 + d)   bus.req_ready = 1'b1;
            else                   bus.req_ready = 1'($urandom_range(0, 1));
            bus.resp_rdata = $urandom;
            if (!to && k == 2 + d + r) begin
                bus.resp_valid = 1'b1; bus.resp_rdata = rd;
            end else if (k >= 2 + d && k <= 2 + d + wl) begin
                bus.resp_valid = 1'b0;
            end else begin
                bus.resp_valid = 1'($urandom_range(0, 1));
            end
            e_stall = (k < last);
            e_valid = (k >= 1 && k <= 1 + d);
            e_wr = (w != 4'd0); e_strb = w; e_addr = a; e_wdata = wd;
            e_rd  = (k >= last) ? new_rd : m_rdata;
            e_err = m_err | (to && k >= last);
            @(posedge clk); #1;
        end
        m_rdata = new_rd;
        m_err   = m_err | to;
        check("handshakes", 32'(hs_cnt - hs0), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: run did not complete");
        $fatal(1);
    end

    initial begin
        en = 1'b0; wen = '0; addr = '0; wdata = '0;
        bus.req_ready = 1'b0; bus.resp_valid = 1'b0; bus.resp_rdata = '0;
        chk_on = 1'b0; m_rdata = '0; m_err = 1'b0;
        #12;
        check("rst_stallreq", 32'(stallreq), 32'd0);
        check("rst_req_valid", 32'(bus.req_valid), 32'd0);
        check("rst_req_wr", 32'(bus.req_wr), 32'd0);
        check("rst_req_wstrb", 32'(bus.req_wstrb), 32'd0);
        check("rst_req_addr", bus.req_addr, 32'd0);
        check("rst_req_wdata", bus.req_wdata, 32'd0);
        check("rst_rdata", data_sram_rdata, 32'd0);
        check("rst_bus_err", 32'(bus_err), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        chk_on = 1'b1;
        idle(2);

        stall_cnt = 0;
        txn(4'b0000, 32'h0000_0100, 32'h0, 32'h1234_5678, 0, 0, 1'b0);
        check("read_stall_cycles", 32'(stall_cnt), 32'd3);
        check("read_rdata_lit", data_sram_rdata, 32'h1234_5678);

        txn(4'b0011, 32'h8000_0010, 32'hAABB_CCDD, $urandom, 0, 1, 1'b0);
        check("write_keeps_rdata", data_sram_rdata, 32'h1234_5678);

        txn(4'b0000, 32'h0000_2000, 32'h0, 32'hCAFE_0001, 5, 2, 1'b0);
        txn(4'b0000, 32'h0000_3000, 32'h0, 32'hCAFE_0002, 0, 0, 1'b1);
        txn(4'b1111, 32'h0000_3004, 32'h0102_0304, $urandom, 1, 0, 1'b0);

        idle(1);
        txn(4'b0000, 32'h0000_4000, 32'h0, 32'h7777_8888, 0, TIMEOUT - 1, 1'b0);
        check("late_resp_no_err", 32'(bus_err), 32'd0);
        check("late_resp_rdata", data_sram_rdata, 32'h7777_8888);

        for (int i = 0; i < 30; i++) begin
            logic [3:0] w;
            idle($urandom_range(0, 2));
            w = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'd0;
            txn(w, $urandom, $urandom, $urandom, $urandom_range(0, 4),
                $urandom_range(0, 6), 1'($urandom_range(0, 1)));
        end

        idle(1);
        txn(4'b0000, 32'h0000_5000, 32'h0, 32'h1111_2222, 1, TIMEOUT, 1'b0);
        check("timeout_rdata", data_sram_rdata, 32'hDEAD_BEEF);
        check("timeout_err", 32'(bus_err), 32'd1);
        txn(4'b0101, 32'h0000_5004, 32'h9999_0000, $urandom, 0, 0, 1'b0);
        check("err_sticky", 32'(bus_err), 32'd1);

        // Reset pulse while the bridge waits for a response
        chk_on = 1'b0;
        en = 1'b1; wen = 4'b0000; addr = 32'h0000_0040;
        bus.req_ready = 1'b0; bus.resp_valid = 1'b0;
        @(posedge clk); #1;
        en = 1'b0; bus.req_ready = 1'b1;
        @(posedge clk); #1;
        bus.req_ready = 1'b0;
        check("wait_stall", 32'(stallreq), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("arst_stallreq", 32'(stallreq), 32'd0);
        check("arst_req_valid", 32'(bus.req_valid), 32'd0);
        check("arst_bus_err", 32'(bus_err), 32'd0);
        check("arst_rdata", data_sram_rdata, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; bus.resp_valid = 1'b1; bus.resp_rdata = 32'h5555_AAAA;
        @(posedge clk); #1;
        bus.resp_valid = 1'b0;
        check("stale_resp_stall", 32'(stallreq), 32'd0);
        check("stale_resp_valid", 32'(bus.req_valid), 32'd0);
        check("stale_resp_rdata", data_sram_rdata, 32'd0);
        m_rdata = '0; m_err = 1'b0;
        chk_on = 1'b1;
        idle(2);
        txn(4'b0000, 32'h0000_6000, 32'h0, 32'h0BAD_F00D, 2, 3, 1'b0);
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
